// File: rtl/pll_lock_detect_pkg.sv
// Shared definitions for the PLL lock detector.
//  - pll_st_e      : lock FSM state encoding, also what the state output carries
//  - PLL_CLK_50_HZ : system clock frequency, shared with the PLL core and display
package pll_lock_detect_pkg;

  typedef enum logic [1:0] {
    PLL_ST_IDLE   = 2'd0,
    PLL_ST_ACQ    = 2'd1,
    PLL_ST_LOCKED = 2'd2
  } pll_st_e;

  localparam int unsigned PLL_CLK_50_HZ = 50_000_000;

endpackage

// File: rtl/pll_lock_detect_rise_detect.sv
// Single-bit rising-edge detector.
//  clk_50 : system clock
//  rst    : synchronous reset, active-high (clears the delayed copy)
//  d      : input, already synchronous to clk_50
//  q_rise : combinational pulse, high in the cycle d is 1 and was 0 last cycle
module rise_detect (
  input  logic clk_50,
  input  logic rst,
  input  logic d,
  output logic q_rise
);

  logic d_1a;

  always_ff @(posedge clk_50) begin
    if (rst) d_1a <= 1'b0;
    else     d_1a <= d;
  end

  assign q_rise = d & ~d_1a;

endmodule

// File: rtl/pll_lock_detect.sv
// PLL lock detector: measures the fb period and the fb->vco phase error, and
// runs an IDLE/ACQ/LOCKED qualifier on the per-period tolerance result.
//  clk_50, rst      : clock, synchronous active-high reset
//  fb, vco          : synchronized feedback and delayed VCO copy
//  meas_valid       : 1-cycle pulse when period/phase_err are updated
//  period           : clk_50 cycles between the last two fb rises
//  phase_err        : signed, +ve = vco lags fb
//  locked, state    : lock status and FSM state (0 IDLE, 1 ACQ, 2 LOCKED)
//  clr_sticky, lost_sticky : loss-of-lock flag and its clear, only when
//                     PLL_LOCK_STICKY_EN is defined
module pll_lock_detect
  import pll_lock_detect_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int LOCK_TOL     = 4,
  parameter int LOCK_COUNT   = 16,
  parameter int UNLOCK_COUNT = 4,
  parameter int TIMEOUT      = 1000
) (
  input  logic             clk_50,
  input  logic             rst,
  input  logic             fb,
  input  logic             vco,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] phase_err,
  output logic             locked,
  output logic [1:0]       state
`ifdef PLL_LOCK_STICKY_EN
  ,
  input  logic             clr_sticky,
  output logic             lost_sticky
`endif
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(UNLOCK_COUNT + 1);

  logic             fb_r, vco_r;
  logic [CNT_W-1:0] per_ctr, ph_q, pe_new, pe_mag;
  logic             vco_seen, eval, in_tol, timeout;
  logic [GW-1:0]    good_ctr, good_nxt, good_inc;
  logic [BW-1:0]    bad_ctr, bad_nxt, bad_inc;
  pll_st_e          st_q, st_nxt;

  rise_detect u_fb_rise  (.clk_50(clk_50), .rst(rst), .d(fb),  .q_rise(fb_r));
  rise_detect u_vco_rise (.clk_50(clk_50), .rst(rst), .d(vco), .q_rise(vco_r));

  // per_ctr doubles as the phase counter: both count cycles since the last fb rise.
  always_ff @(posedge clk_50) begin
    if (rst) begin
      per_ctr  <= '0;
      ph_q     <= '0;
      vco_seen <= 1'b0;
    end else begin
      if (fb_r)              per_ctr <= CNT_W'(1);
      else if (per_ctr != '1) per_ctr <= per_ctr + CNT_W'(1);
      // A vco rise coincident with fb belongs to the new period at phase 0.
      if (vco_r) begin
        ph_q     <= fb_r ? '0 : per_ctr;
        vco_seen <= 1'b1;
      end else if (fb_r) begin
        vco_seen <= 1'b0;
      end
    end
  end

  // Phase folded into (-period/2, period/2]; magnitude via two's complement.
  assign pe_new  = (ph_q <= (per_ctr >> 1)) ? ph_q : ph_q - per_ctr;
  assign pe_mag  = pe_new[CNT_W-1] ? CNT_W'(0) - pe_new : pe_new;
  assign in_tol  = vco_seen && (pe_mag <= CNT_W'(LOCK_TOL));
  assign eval    = fb_r && (st_q != PLL_ST_IDLE);
  assign timeout = !fb_r && (per_ctr == CNT_W'(TIMEOUT));
  assign good_inc = good_ctr + GW'(1);
  assign bad_inc  = bad_ctr + BW'(1);

  always_ff @(posedge clk_50) begin
    if (rst) begin
      meas_valid <= 1'b0;
      period     <= '0;
      phase_err  <= '0;
    end else begin
      meas_valid <= eval;
      if (eval) begin
        period <= per_ctr;
        if (vco_seen) phase_err <= pe_new;
      end
    end
  end

  always_ff @(posedge clk_50) begin
    if (rst) begin
      st_q     <= PLL_ST_IDLE;
      good_ctr <= '0;
      bad_ctr  <= '0;
      locked   <= 1'b0;
    end else begin
      st_q     <= st_nxt;
      good_ctr <= good_nxt;
      bad_ctr  <= bad_nxt;
      locked   <= (st_nxt == PLL_ST_LOCKED);
    end
  end

  always_comb begin
    st_nxt   = st_q;
    good_nxt = good_ctr;
    bad_nxt  = bad_ctr;
    case (st_q)
      PLL_ST_IDLE: begin
        good_nxt = '0;
        bad_nxt  = '0;
        if (fb_r) st_nxt = PLL_ST_ACQ;
      end
      PLL_ST_ACQ: if (eval) begin
        bad_nxt = '0;
        if (in_tol) begin
          good_nxt = good_inc;
          if (good_inc == GW'(LOCK_COUNT)) st_nxt = PLL_ST_LOCKED;
        end else begin
          good_nxt = '0;
        end
      end
      PLL_ST_LOCKED: if (eval) begin
        if (!in_tol) begin
          bad_nxt = bad_inc;
          if (bad_inc == BW'(UNLOCK_COUNT)) begin
            st_nxt   = PLL_ST_ACQ;
            good_nxt = '0;
          end
        end else begin
          bad_nxt = '0;
        end
      end
      default: st_nxt = PLL_ST_IDLE;
    endcase
    if (timeout) begin
      st_nxt   = PLL_ST_IDLE;
      good_nxt = '0;
      bad_nxt  = '0;
    end
  end

  assign state = st_q;

`ifdef PLL_LOCK_STICKY_EN
  // Set on any exit from LOCKED; a same-cycle clear loses to the set.
  always_ff @(posedge clk_50) begin
    if (rst)                                                  lost_sticky <= 1'b0;
    else if (st_q == PLL_ST_LOCKED && st_nxt != PLL_ST_LOCKED) lost_sticky <= 1'b1;
    else if (clr_sticky)                                      lost_sticky <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_pll_lock_detect.sv
// Testbench for pll_lock_detect: directed lock/unlock/timeout/reset scenarios
// plus randomized periods and phases, all checked every cycle against a
// timestamp-based reference model. Sticky checks only with PLL_LOCK_STICKY_EN.
module tb_pll_lock_detect;

  logic        clk_50 = 1'b0;
  logic        rst = 1'b1, fb = 1'b0, vco = 1'b0;
  logic        meas_valid, locked;
  logic [15:0] period, phase_err;
  logic [1:0]  state;
`ifdef PLL_LOCK_STICKY_EN
  logic        clr_sticky = 1'b0;
  logic        lost_sticky;
`endif

  pll_lock_detect dut (
    .clk_50(clk_50), .rst(rst), .fb(fb), .vco(vco),
`ifdef PLL_LOCK_STICKY_EN
    .clr_sticky(clr_sticky), .lost_sticky(lost_sticky),
`endif
    .meas_valid(meas_valid), .period(period), .phase_err(phase_err),
    .locked(locked), .state(state)
  );

  always #5 clk_50 = ~clk_50;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  int n_chk = 0, n_err = 0, n = 0, n_meas = 0;
  bit clr_k0 = 1'b0;

  // reference model state: absolute step timestamps
  int  m_anchor = 0, m_last_vco = -1000000, m_st = 0, m_good = 0, m_bad = 0;
  bit  m_prev_fb = 0, m_prev_vco = 0;
  bit  e_mv = 0, e_sticky = 0;
  logic [15:0] e_period = '0, e_pe = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic ref_step(input bit f, input bit v, input bit r, input bit c);
    bit fr, vr, seen, ok, was_locked;
    int age, ph, pe;
    if (r) begin
      m_anchor = n + 1; m_last_vco = -1000000; m_st = 0; m_good = 0; m_bad = 0;
      m_prev_fb = 0; m_prev_vco = 0; e_mv = 0; e_period = '0; e_pe = '0; e_sticky = 0;
      return;
    end
    fr = f && !m_prev_fb;
    vr = v && !m_prev_vco;
    age = n - m_anchor;
    was_locked = (m_st == 2);
    e_mv = 0;
    if (fr) begin
      if (m_st != 0) begin
        e_mv = 1;
        e_period = 16'(age);
        seen = (m_last_vco >= m_anchor);
        ph = m_last_vco - m_anchor;
        pe = (ph <= age / 2) ? ph : ph - age;
        if (seen) e_pe = 16'(pe);
        ok = seen && ((pe < 0 ? -pe : pe) <= 4);
        if (m_st == 1) begin
          m_good = ok ? m_good + 1 : 0;
          m_bad = 0;
          if (m_good == 16) m_st = 2;
        end else begin
          m_bad = ok ? 0 : m_bad + 1;
          if (m_bad == 4) begin m_st = 1; m_good = 0; m_bad = 0; end
        end
      end else begin
        m_st = 1; m_good = 0; m_bad = 0;
      end
      m_anchor = n;
    end else if (age == 1000) begin
      m_st = 0; m_good = 0; m_bad = 0;
    end
    if (vr) m_last_vco = n;
    if (was_locked && m_st != 2) e_sticky = 1;
    else if (c)                  e_sticky = 0;
    m_prev_fb = f;
    m_prev_vco = v;
  endtask

  task automatic step(input bit f, input bit v, input bit r, input bit c);
    fb = f; vco = v; rst = r;
`ifdef PLL_LOCK_STICKY_EN
    clr_sticky = c;
`endif
    @(posedge clk_50);
    ref_step(f, v, r, c);
    #1;
    chk($sformatf("cyc%0d", n), {28'd0, meas_valid, period, phase_err, locked, state},
        {28'd0, e_mv, e_period, e_pe, (m_st == 2), 2'(m_st)});
`ifdef PLL_LOCK_STICKY_EN
    chk($sformatf("sticky%0d", n), {63'd0, lost_sticky}, {63'd0, e_sticky});
`endif
    if (meas_valid) n_meas++;
    n++;
  endtask

  // fb: 50% duty, rising at k=0. vco: same shape, rising at k=off (0 <= off < p).
  task automatic run_steps(input int p, input int off, input bit en, input int cnt);
    bit f, v;
    for (int k = 0; k < cnt; k++) begin
      f = (k < p / 2);
      v = en && (((k - off + p) % p) < p / 2);
      step(f, v, 1'b0, (k == 0) && clr_k0);
    end
  endtask

  task automatic run_period(input int p, input int off, input bit en);
    run_steps(p, off, en, p);
  endtask

  initial begin
    int mv0, idle_at, mv_stop, p, off, sel;
    bit en, good_blk;

    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("rst_state", {28'd0, meas_valid, period, phase_err, locked, state}, 64'd0);

    // 1: period 400, vco lags by 2
    mv0 = n_meas;
    for (int i = 0; i < 16; i++) run_period(400, 2, 1);
    chk("t1_mv_count15", 64'(n_meas - mv0), 64'd15);
    chk("t1_not_locked", {63'd0, locked}, 64'd0);
    chk("t1_period", {48'd0, period}, 64'd400);
    chk("t1_phase", {48'd0, phase_err}, 64'd2);
    run_period(400, 2, 1);
    chk("t1_locked", {63'd0, locked}, 64'd1);
    chk("t1_state", {62'd0, state}, 64'd2);

    // 2: vco now leads by 10 -> unlock after exactly 4 bad periods
    for (int i = 0; i < 4; i++) run_period(400, 390, 1);
    chk("t2_still_locked", {63'd0, locked}, 64'd1);
    run_period(400, 390, 1);
    chk("t2_unlocked", {63'd0, locked}, 64'd0);
    chk("t2_state_acq", {62'd0, state}, 64'd1);
    chk("t2_phase", {48'd0, phase_err}, 64'hFFF6);
`ifdef PLL_LOCK_STICKY_EN
    chk("t2_sticky", {63'd0, lost_sticky}, 64'd1);
`endif

    // 3: relock at period 100, then stop fb
    for (int i = 0; i < 20; i++) run_period(100, 2, 1);
    chk("t3_locked", {63'd0, locked}, 64'd1);
    idle_at = -1; mv_stop = 0;
    for (int j = 1; j <= 1100; j++) begin
      step(0, 0, 0, 0);
      if (meas_valid) mv_stop++;
      if (idle_at < 0 && state == 2'd0) idle_at = j;
    end
    chk("t3_idle_step", 64'(idle_at), 64'd901);
    chk("t3_no_mv", 64'(mv_stop), 64'd0);
    chk("t3_locked_low", {63'd0, locked}, 64'd0);

    // 4: vco coincident with fb, then one vco-less period
    for (int i = 0; i < 5; i++) run_period(100, 0, 1);
    chk("t4_phase0", {48'd0, phase_err}, 64'd0);
    chk("t4_acq", {62'd0, state}, 64'd1);
    run_period(100, 0, 0);
    for (int i = 0; i < 16; i++) run_period(100, 0, 1);
    chk("t4_restart_not_locked", {63'd0, locked}, 64'd0);
    chk("t4_phase_kept", {48'd0, phase_err}, 64'd0);
    run_period(100, 0, 1);
    chk("t4_locked", {63'd0, locked}, 64'd1);

    // 5: reset with good count at 10
    step(0, 0, 1, 0);
    for (int i = 0; i < 10; i++) run_period(100, 3, 1);
    run_steps(100, 3, 1, 70);
    chk("t5_acq", {62'd0, state}, 64'd1);
    step(0, 0, 1, 0);
    chk("t5_rst_outs", {28'd0, meas_valid, period, phase_err, locked, state}, 64'd0);
    for (int i = 0; i < 16; i++) run_period(100, 3, 1);
    chk("t5_not_locked", {63'd0, locked}, 64'd0);
    run_period(100, 3, 1);
    chk("t5_relocked", {63'd0, locked}, 64'd1);

`ifdef PLL_LOCK_STICKY_EN
    // 6: clear coincident with lock loss -> set wins
    chk("t6_sticky_clr_by_rst", {63'd0, lost_sticky}, 64'd0);
    for (int i = 0; i < 4; i++) run_period(100, 90, 1);
    clr_k0 = 1'b1;
    run_period(100, 90, 1);
    chk("t6_loss", {62'd0, state}, 64'd1);
    chk("t6_set_wins", {63'd0, lost_sticky}, 64'd1);
    run_steps(100, 90, 1, 1);
    clr_k0 = 1'b0;
    chk("t6_cleared", {63'd0, lost_sticky}, 64'd0);
`endif

    // random: alternating mostly-good and mixed blocks
    for (int b = 0; b < 6; b++) begin
      good_blk = (b % 2 == 0);
      for (int i = 0; i < 25; i++) begin
        p = int'($urandom_range(160, 40));
        sel = int'($urandom_range(99, 0));
        if (sel < (good_blk ? 97 : 50))
          off = ($urandom_range(1, 0) != 0) ? int'($urandom_range(4, 0)) : p - int'($urandom_range(4, 1));
        else
          off = int'($urandom_range(p - 1, 0));
        en = (!good_blk && $urandom_range(9, 0) == 0) ? 1'b0 : 1'b1;
        clr_k0 = ($urandom_range(3, 0) == 0);
        run_period(p, off, en);
      end
      if (b == 3) for (int j = 0; j < 1010; j++) step(0, 0, 0, 0);
    end
    clr_k0 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
